// File: rtl/database_reader_pkg.sv
// Shared debug-unit definitions: reader state encoding and counter sizing helper.
package database_reader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SELECT  = 3'd1,
      ST_LOAD    = 3'd2,
      ST_SEND    = 3'd3,
      ST_WAIT_TX = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   // Bits needed to hold values 0 .. value-1 (at least 1).
   function automatic int unsigned clogb2(input int unsigned value);
      int unsigned res;
      res = 1;
      while ((64'd1 << res) < 64'(value)) res = res + 1;
      return res;
   endfunction

endpackage

// File: rtl/database_reader.sv
// Walks the database snapshot selector through every code and streams each
// captured word MSB-byte-first onto the UART TX byte handshake.
module database_reader
   import database_reader_pkg::*;
#(
   parameter int unsigned LONGITUD_INSTRUCCION = 32,
   parameter int unsigned CANT_BITS_CONTROL    = 4,
   parameter int unsigned CANT_DATOS           = 12,
   parameter int unsigned LATENCIA_LECTURA     = 1
) (
   input  logic                            i_clock,
   input  logic                            i_soft_reset,
   input  logic                            i_start,
   output logic [CANT_BITS_CONTROL-1:0]    o_control,
   input  logic [LONGITUD_INSTRUCCION-1:0] i_dato,
   output logic [7:0]                      o_tx_data,
   output logic                            o_tx_start,
   input  logic                            i_tx_done,
   output logic                            o_busy,
   output logic                            o_done
);

   localparam int unsigned BYTES  = LONGITUD_INSTRUCCION / 8;
   localparam int unsigned BYTE_W = clogb2(BYTES + 1);
   localparam int unsigned LAT_W  = clogb2(LATENCIA_LECTURA + 1);

   state_t                          state, state_nx;
   logic [CANT_BITS_CONTROL-1:0]    index_q, index_nx;
   logic [LAT_W-1:0]                lat_q, lat_nx;
   logic [BYTE_W-1:0]               bytes_q, bytes_nx;
   logic [LONGITUD_INSTRUCCION-1:0] shift_q, shift_nx;

   // State register
   always_ff @(posedge i_clock or posedge i_soft_reset) begin
      if (i_soft_reset) state <= ST_IDLE;
      else              state <= state_nx;
   end

   // Next-state and datapath updates
   always_comb begin
      state_nx = state;
      index_nx = index_q;
      lat_nx   = lat_q;
      bytes_nx = bytes_q;
      shift_nx = shift_q;
      case (state)
         ST_IDLE: begin
            if (i_start) begin
               state_nx = ST_SELECT;
               index_nx = '0;
               lat_nx   = '0;
            end
         end
         ST_SELECT: begin
            if (lat_q == LAT_W'(LATENCIA_LECTURA - 1)) state_nx = ST_LOAD;
            else                                       lat_nx   = lat_q + LAT_W'(1);
         end
         ST_LOAD: begin
            shift_nx = i_dato;
            bytes_nx = BYTE_W'(BYTES);
            state_nx = ST_SEND;
         end
         ST_SEND: state_nx = ST_WAIT_TX;
         ST_WAIT_TX: begin
            // bytes_q counts the byte on the wire plus those still queued
            if (i_tx_done) begin
               if (bytes_q > BYTE_W'(1)) begin
                  shift_nx = shift_q << 8;
                  bytes_nx = bytes_q - BYTE_W'(1);
                  state_nx = ST_SEND;
               end else if (index_q < CANT_BITS_CONTROL'(CANT_DATOS - 1)) begin
                  index_nx = index_q + CANT_BITS_CONTROL'(1);
                  lat_nx   = '0;
                  state_nx = ST_SELECT;
               end else begin
                  state_nx = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            index_nx = '0;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Datapath registers and registered outputs decoded from the next state
   always_ff @(posedge i_clock or posedge i_soft_reset) begin
      if (i_soft_reset) begin
         index_q    <= '0;
         lat_q      <= '0;
         bytes_q    <= '0;
         shift_q    <= '0;
         o_tx_start <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         index_q    <= index_nx;
         lat_q      <= lat_nx;
         bytes_q    <= bytes_nx;
         shift_q    <= shift_nx;
         o_tx_start <= (state_nx == ST_SEND);
         o_busy     <= (state_nx != ST_IDLE);
         o_done     <= (state_nx == ST_DONE);
      end
   end

   assign o_control = index_q;
   assign o_tx_data = shift_q[LONGITUD_INSTRUCCION-1 -: 8];

endmodule

// File: tb/tb_database_reader.sv
// Bench for database_reader: stub database with garbage-then-valid latency,
// stub UART TX, and a byte scoreboard fed when each dump is requested.
module tb_database_reader;

   localparam int unsigned LI    = 32;
   localparam int unsigned CB    = 4;
   localparam int unsigned CD    = 12;
   localparam int unsigned LAT   = 1;
   localparam int unsigned BYTES = LI / 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_start = 1'b0;
   logic [CB-1:0] o_control;
   logic [LI-1:0] i_dato;
   logic [7:0]    o_tx_data;
   logic          o_tx_start;
   logic          i_tx_done = 1'b0;
   logic          o_busy;
   logic          o_done;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int nbytes = 0;
   int ndone = 0;
   int done_cyc = 0;
   bit fast = 1'b0;
   bit inject = 1'b0;
   bit idle_pulse = 1'b0;
   int tx_cnt = 0;
   logic [7:0] exp_q[$];
   logic [CB-1:0] ctrl_d = '0;

   database_reader #(
      .LONGITUD_INSTRUCCION(LI),
      .CANT_BITS_CONTROL(CB),
      .CANT_DATOS(CD),
      .LATENCIA_LECTURA(LAT)
   ) dut (
      .i_clock(clk),
      .i_soft_reset(rst),
      .i_start(i_start),
      .o_control(o_control),
      .i_dato(i_dato),
      .o_tx_data(o_tx_data),
      .o_tx_start(o_tx_start),
      .i_tx_done(i_tx_done),
      .o_busy(o_busy),
      .o_done(o_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Stub database: garbage until LAT cycles after a selector change
   always @(posedge clk) ctrl_d <= o_control;
   assign i_dato = (ctrl_d == o_control) ? {4{o_control, 4'h0}} : 32'hDEADBEEF;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Stub UART TX: done 3 cycles after each start, or tied high in fast mode
   always @(negedge clk) begin
      if (rst) begin
         tx_cnt = 0;
         i_tx_done = 1'b0;
      end else if (fast) begin
         i_tx_done = 1'b1;
      end else if (o_tx_start) begin
         tx_cnt = 3;
         i_tx_done = inject;
      end else if (tx_cnt != 0) begin
         tx_cnt = tx_cnt - 1;
         i_tx_done = (tx_cnt == 0);
      end else begin
         i_tx_done = idle_pulse;
      end
   end

   // Output monitor: every transmitted byte is popped against the scoreboard
   always @(negedge clk) begin
      if (o_tx_start) begin
         nbytes = nbytes + 1;
         if (exp_q.size() == 0) check("extra_byte", {24'h0, o_tx_data}, 32'hFFFF_FFFF);
         else                   check("byte", {24'h0, o_tx_data}, {24'h0, exp_q.pop_front()});
      end
      if (o_done) begin
         ndone = ndone + 1;
         done_cyc = cyc;
      end
   end

   task automatic start_dump(output int sc);
      logic [CB-1:0] c;
      for (int w = 0; w < int'(CD); w++) begin
         c = CB'(w);
         for (int b = 0; b < int'(BYTES); b++) exp_q.push_back({c, 4'h0});
      end
      @(negedge clk) i_start = 1'b1;
      @(negedge clk) i_start = 1'b0;
      sc = cyc;
      check("busy_after_start", 32'(o_busy), 32'd1);
      check("control_after_start", 32'(o_control), 32'd0);
   endtask

   task automatic wait_done(input int budget);
      int d0;
      int i;
      d0 = ndone;
      i = 0;
      while (i < budget && ndone == d0) begin
         @(posedge clk);
         i = i + 1;
      end
      check("done_timeout", 32'(ndone != d0), 32'd1);
      @(negedge clk);
   endtask

   initial begin
      int sc;
      int n0;
      int d0;
      int i;

      // Asynchronous reset before any clock edge
      #3;
      check("rst_control", 32'(o_control), 32'd0);
      check("rst_tx_data", 32'(o_tx_data), 32'd0);
      check("rst_tx_start", 32'(o_tx_start), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Full dump with slow UART, first-byte latency
      n0 = nbytes; d0 = ndone;
      start_dump(sc);
      i = 0;
      while (!o_tx_start && i < 20) begin
         @(negedge clk);
         i = i + 1;
      end
      check("first_tx_latency", 32'(cyc - sc), 32'(LAT + 1));
      wait_done(2000);
      check("slow_byte_count", 32'(nbytes - n0), 32'(CD * BYTES));
      check("slow_queue_empty", 32'(exp_q.size()), 32'd0);
      check("slow_done_count", 32'(ndone - d0), 32'd1);
      check("busy_after_done", 32'(o_busy), 32'd0);
      check("done_single_pulse", 32'(o_done), 32'd0);

      // Fast UART: total length from start edge to o_done
      fast = 1'b1;
      n0 = nbytes;
      start_dump(sc);
      wait_done(2000);
      fast = 1'b0;
      check("fast_dump_length", 32'(done_cyc - sc), 32'(CD * (LAT + 1 + 2 * BYTES)));
      check("fast_byte_count", 32'(nbytes - n0), 32'(CD * BYTES));
      repeat (3) @(negedge clk);

      // Ignored inputs: tx_done in IDLE and SEND, start pulses while busy
      n0 = nbytes; d0 = ndone;
      idle_pulse = 1'b1;
      repeat (5) @(negedge clk);
      idle_pulse = 1'b0;
      @(negedge clk);
      check("idle_no_tx", 32'(nbytes - n0), 32'd0);
      inject = 1'b1;
      start_dump(sc);
      for (int k = 0; k < 5; k++) begin
         repeat (20) @(negedge clk);
         i_start = 1'b1;
         @(negedge clk) i_start = 1'b0;
      end
      wait_done(2000);
      inject = 1'b0;
      repeat (40) @(negedge clk);
      check("ignored_byte_count", 32'(nbytes - n0), 32'(CD * BYTES));
      check("ignored_done_count", 32'(ndone - d0), 32'd1);
      check("ignored_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset mid-dump after the 5th byte, then restart from code 0
      n0 = nbytes;
      start_dump(sc);
      i = 0;
      while ((nbytes - n0) < 5 && i < 500) begin
         @(posedge clk);
         i = i + 1;
      end
      check("reach_5th_byte", 32'(nbytes - n0), 32'd5);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_control", 32'(o_control), 32'd0);
      check("midrst_tx_data", 32'(o_tx_data), 32'd0);
      check("midrst_tx_start", 32'(o_tx_start), 32'd0);
      check("midrst_busy", 32'(o_busy), 32'd0);
      check("midrst_done", 32'(o_done), 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n0 = nbytes;
      repeat (20) @(negedge clk);
      check("no_tx_after_reset", 32'(nbytes - n0), 32'd0);
      d0 = ndone;
      start_dump(sc);
      wait_done(2000);
      check("restart_byte_count", 32'(nbytes - n0), 32'(CD * BYTES));
      check("restart_done_count", 32'(ndone - d0), 32'd1);
      check("restart_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
